// File: rtl/stage_spawner.sv
// Stage spawner: places the initial stage after reset, then on request draws a
// pseudo-random position/width for the next stage, launches its fall, paces the
// animator with a divided pulse and reports landing back to the game FSM.
module stage_spawner #(
   parameter int unsigned X_MIN      = 40,
   parameter int unsigned X_MAX      = 600,
   parameter int unsigned MIN_GAP    = 80,
   parameter int unsigned MAX_GAP    = 240,
   parameter int unsigned W_MIN      = 40,
   parameter int unsigned W_STEP     = 20,
   parameter int unsigned INIT_X     = 320,
   parameter int unsigned INIT_W     = 80,
   parameter int unsigned PULSE_DIV  = 500000,
   parameter int unsigned DRAW_TRIES = 8,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spawn_req,
   input  logic       fall_fin,
   output logic       generate_en,
   output logic       update,
   output logic       enable,
   output logic       pulse,
   output logic [9:0] stage_x2,
   output logic [9:0] stage_w2,
   output logic [9:0] cur_x,
   output logic       spawn_busy,
   output logic       spawn_done
);

   localparam int unsigned CNT_W = $clog2(PULSE_DIV);
   localparam int unsigned TRY_W = $clog2(DRAW_TRIES + 1);

   localparam logic [9:0]  X_MIN_P     = 10'(X_MIN);
   localparam logic [9:0]  X_MAX_P     = 10'(X_MAX);
   localparam logic [9:0]  MIN_GAP_P   = 10'(MIN_GAP);
   localparam logic [7:0]  GAP_RANGE_P = 8'(MAX_GAP - MIN_GAP);
   localparam logic [9:0]  W_MIN_P     = 10'(W_MIN);
   localparam logic [9:0]  W_STEP_P    = 10'(W_STEP);
   localparam logic [9:0]  INIT_X_P    = 10'(INIT_X);
   localparam logic [9:0]  INIT_W_P    = 10'(INIT_W);
   localparam logic [15:0] LFSR_TAPS   = 16'hB400;  // x^16+x^14+x^13+x^11+1

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StDraw,
      StLoad,
      StFall,
      StDone
   } state_e;

   state_e           state_q;
   logic [15:0]      lfsr_q;
   logic [TRY_W-1:0] tries_q;
   logic [CNT_W-1:0] div_cnt_q;

   logic [15:0] lfsr_next;
   logic        accept;
   logic        exhaust;
   logic [10:0] gap;
   logic [10:0] x_right;
   logic [9:0]  x_left;
   logic [9:0]  x_far;
   logic        right_ok;
   logic        left_ok;
   logic [9:0]  draw_x;
   logic [9:0]  draw_w;

   // Galois LFSR next state (right-shifting form)
   always_comb begin
      lfsr_next = lfsr_q >> 1;
      if (lfsr_q[0]) begin
         lfsr_next = (lfsr_q >> 1) ^ LFSR_TAPS;
      end
   end

   // Candidate stage from the current LFSR value, evaluated every DRAW cycle
   always_comb begin
      accept   = (lfsr_q[7:0] <= GAP_RANGE_P);
      exhaust  = (tries_q == TRY_W'(DRAW_TRIES - 1));
      gap      = accept ? ({1'b0, MIN_GAP_P} + {3'b000, lfsr_q[7:0]}) : {1'b0, MIN_GAP_P};
      x_right  = {1'b0, cur_x} + gap;
      x_left   = cur_x - gap[9:0];
      right_ok = (x_right <= {1'b0, X_MAX_P});
      left_ok  = ({1'b0, cur_x} >= ({1'b0, X_MIN_P} + gap));
      // Fallback: pin to whichever edge is farther away
      x_far    = ((cur_x - X_MIN_P) >= (X_MAX_P - cur_x)) ? X_MIN_P : X_MAX_P;
      if (lfsr_q[8]) begin
         draw_x = right_ok ? x_right[9:0] : (left_ok ? x_left : x_far);
      end else begin
         draw_x = left_ok ? x_left : (right_ok ? x_right[9:0] : x_far);
      end
      draw_w = W_MIN_P + 10'(lfsr_q[10:9]) * W_STEP_P;
   end

   // Sequencer FSM; every output is registered and aligned with its state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StInit;
         lfsr_q      <= SEED;
         tries_q     <= '0;
         div_cnt_q   <= '0;
         stage_x2    <= INIT_X_P;
         stage_w2    <= INIT_W_P;
         cur_x       <= INIT_X_P;
         generate_en <= 1'b0;
         update      <= 1'b0;
         enable      <= 1'b0;
         pulse       <= 1'b0;
         spawn_busy  <= 1'b0;
         spawn_done  <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_next;
         generate_en <= 1'b0;
         update      <= 1'b0;
         pulse       <= 1'b0;
         spawn_done  <= 1'b0;
         case (state_q)
            StInit: begin
               generate_en <= 1'b1;
               state_q     <= StIdle;
            end
            StIdle: begin
               if (spawn_req) begin
                  spawn_busy <= 1'b1;
                  tries_q    <= '0;
                  state_q    <= StDraw;
               end
            end
            StDraw: begin
               if (accept || exhaust) begin
                  stage_x2 <= draw_x;
                  stage_w2 <= draw_w;
                  update   <= 1'b1;
                  state_q  <= StLoad;
               end else begin
                  tries_q <= tries_q + 1'b1;
               end
            end
            StLoad: begin
               enable    <= 1'b1;
               div_cnt_q <= '0;
               state_q   <= StFall;
            end
            StFall: begin
               if (fall_fin) begin
                  enable     <= 1'b0;
                  spawn_done <= 1'b1;
                  cur_x      <= stage_x2;
                  state_q    <= StDone;
               end else begin
                  // div_cnt_q holds (fall cycle - 1) mod PULSE_DIV
                  pulse <= (div_cnt_q == CNT_W'(PULSE_DIV - 2));
                  if (div_cnt_q == CNT_W'(PULSE_DIV - 1)) begin
                     div_cnt_q <= '0;
                  end else begin
                     div_cnt_q <= div_cnt_q + 1'b1;
                  end
               end
            end
            StDone: begin
               spawn_busy <= 1'b0;
               state_q    <= StIdle;
            end
            default: begin
               state_q <= StInit;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_spawner.sv
// Self-checking bench for stage_spawner: a behavioural model predicts every draw
// from the LFSR polynomial and the placement rules, and the bench drives the
// animator side (fall_fin) itself.
module tb_stage_spawner;

   localparam int DIV     = 4;
   localparam int X_MIN   = 40;
   localparam int X_MAX   = 600;
   localparam int MIN_GAP = 80;
   localparam int MAX_GAP = 240;
   localparam int W_MIN   = 40;
   localparam int W_STEP  = 20;
   localparam int INIT_X  = 320;
   localparam int INIT_W  = 80;
   localparam int TRIES   = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spawn_req = 1'b0;
   logic       fall_fin = 1'b0;
   logic       generate_en, update, enable, pulse, spawn_busy, spawn_done;
   logic [9:0] stage_x2, stage_w2, cur_x;

   int checks = 0;
   int failures = 0;

   logic [15:0] m_lfsr;
   int          m_cur;

   stage_spawner #(
      .PULSE_DIV(DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spawn_req  (spawn_req),
      .fall_fin   (fall_fin),
      .generate_en(generate_en),
      .update     (update),
      .enable     (enable),
      .pulse      (pulse),
      .stage_x2   (stage_x2),
      .stage_w2   (stage_w2),
      .cur_x      (cur_x),
      .spawn_busy (spawn_busy),
      .spawn_done (spawn_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Reference LFSR: reset to SEED, otherwise one step per clock
   always @(posedge clk) begin
      if (rst) m_lfsr <= SEED;
      else m_lfsr <= lfsr_step(m_lfsr);
   end

   function automatic bit all_reject(input logic [15:0] s);
      logic [15:0] l;
      l = s;
      for (int i = 0; i < TRIES; i++) begin
         if (int'(l[7:0]) <= MAX_GAP - MIN_GAP) return 1'b0;
         l = lfsr_step(l);
      end
      return 1'b1;
   endfunction

   // Expected draw length, x and width given the LFSR in the first DRAW cycle
   task automatic predict(input logic [15:0] first, input int cur, output int ncyc,
                          output int x, output int w);
      logic [15:0] l;
      int gap;
      bit  done;
      l = first;
      gap = MIN_GAP;
      ncyc = 0;
      done = 1'b0;
      while (!done) begin
         ncyc++;
         if (int'(l[7:0]) <= MAX_GAP - MIN_GAP) begin
            gap = MIN_GAP + int'(l[7:0]);
            done = 1'b1;
         end else if (ncyc == TRIES) begin
            done = 1'b1;
         end else begin
            l = lfsr_step(l);
         end
      end
      w = W_MIN + int'(l[10:9]) * W_STEP;
      if (l[8]) begin
         if (cur + gap <= X_MAX) x = cur + gap;
         else if (cur - gap >= X_MIN) x = cur - gap;
         else x = (cur - X_MIN >= X_MAX - cur) ? X_MIN : X_MAX;
      end else begin
         if (cur - gap >= X_MIN) x = cur - gap;
         else if (cur + gap <= X_MAX) x = cur + gap;
         else x = (cur - X_MIN >= X_MAX - cur) ? X_MIN : X_MAX;
      end
   endtask

   // One full spawn from IDLE; returns early at the rst_pulse-th pulse if nonzero
   task automatic run_spawn(input int n_pulses, input int fin_delay, input bit hold_req,
                            input int rst_pulse, output int draw_seen);
      int ncyc, ex, ew, c_fin, npul, dx;
      logic [5:0] flags, exp_flags;
      predict(lfsr_step(m_lfsr), m_cur, ncyc, ex, ew);
      spawn_req = 1'b1;
      @(negedge clk);
      if (!hold_req) spawn_req = 1'b0;
      draw_seen = 0;
      while (update !== 1'b1 && draw_seen < 40) begin
         checks++;
         flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
         if (flags !== 6'b000010) begin
            failures++;
            $display("FAIL draw_flags got=%b want=000010", flags);
         end
         draw_seen++;
         @(negedge clk);
      end
      checks++;
      if (draw_seen != ncyc) begin
         failures++;
         $display("FAIL draw_cycles got=%0d want=%0d", draw_seen, ncyc);
      end
      if (draw_seen >= 40) begin
         spawn_req = 1'b0;
         return;
      end
      checks++;
      if (stage_x2 !== 10'(ex) || stage_w2 !== 10'(ew)) begin
         failures++;
         $display("FAIL load_xw got=%0d/%0d want=%0d/%0d", stage_x2, stage_w2, ex, ew);
      end
      checks++;
      flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
      if (flags !== 6'b010010) begin
         failures++;
         $display("FAIL load_flags got=%b want=010010", flags);
      end
      @(negedge clk);
      c_fin = n_pulses * DIV + fin_delay;
      if (c_fin < 1) c_fin = 1;
      npul = 0;
      for (int c = 1; c <= c_fin; c++) begin
         exp_flags = {3'b001, (c % DIV == 0), 2'b10};
         if (c % DIV == 0) npul++;
         checks++;
         flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
         if (flags !== exp_flags) begin
            failures++;
            $display("FAIL fall_flags cyc=%0d got=%b want=%b", c, flags, exp_flags);
         end
         if (rst_pulse > 0 && npul == rst_pulse && c % DIV == 0) begin
            spawn_req = 1'b0;
            return;
         end
         if (c == c_fin) fall_fin = 1'b1;
         @(negedge clk);
      end
      fall_fin = 1'b0;
      checks++;
      flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
      if (flags !== 6'b000011) begin
         failures++;
         $display("FAIL done_flags got=%b want=000011", flags);
      end
      spawn_req = 1'b0;
      @(negedge clk);
      checks++;
      flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
      if (flags !== 6'b000000) begin
         failures++;
         $display("FAIL idle_flags got=%b want=000000", flags);
      end
      checks++;
      if (cur_x !== 10'(ex) || cur_x !== stage_x2) begin
         failures++;
         $display("FAIL commit_cur_x got=%0d want=%0d", cur_x, ex);
      end
      dx = int'(cur_x) - m_cur;
      if (dx < 0) dx = -dx;
      checks++;
      if (dx < MIN_GAP || dx > MAX_GAP || int'(cur_x) < X_MIN || int'(cur_x) > X_MAX) begin
         failures++;
         $display("FAIL x_bounds got=%0d dx=%0d", cur_x, dx);
      end
      m_cur = ex;
   endtask

   task automatic test_reset(input int n);
      logic [5:0] flags;
      rst = 1'b1;
      spawn_req = 1'b0;
      fall_fin = 1'b0;
      repeat (n) @(negedge clk);
      checks++;
      flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
      if (flags !== 6'b000000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=000000", flags);
      end
      checks++;
      if (cur_x !== 10'(INIT_X) || stage_x2 !== 10'(INIT_X) || stage_w2 !== 10'(INIT_W)) begin
         failures++;
         $display("FAIL reset_xw got=%0d/%0d/%0d want=%0d/%0d/%0d", cur_x, stage_x2, stage_w2,
                  INIT_X, INIT_X, INIT_W);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
      if (flags !== 6'b100000) begin
         failures++;
         $display("FAIL init_generate got=%b want=100000", flags);
      end
      @(negedge clk);
      checks++;
      flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
      if (flags !== 6'b000000) begin
         failures++;
         $display("FAIL init_idle got=%b want=000000", flags);
      end
      m_cur = INIT_X;
   endtask

   task automatic test_idle_fall_fin();
      logic [5:0] flags;
      fall_fin = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         flags = {generate_en, update, enable, pulse, spawn_busy, spawn_done};
         if (flags !== 6'b000000) begin
            failures++;
            $display("FAIL idle_fall_fin got=%b want=000000", flags);
         end
      end
      fall_fin = 1'b0;
   endtask

   task automatic test_spawn_basic();
      int d;
      run_spawn(101, 0, 1'b0, 0, d);
      run_spawn(3, DIV - 1, 1'b0, 0, d);
   endtask

   task automatic test_exhaust();
      logic [15:0] cand;
      int d, prev, dx, seen;
      bit found;
      cand = lfsr_step(m_lfsr);
      found = 1'b0;
      d = 0;
      while (!found && d < 20000) begin
         if (all_reject(cand)) found = 1'b1;
         else begin
            cand = lfsr_step(cand);
            d++;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL exhaust_search got=none want=8-reject window");
         return;
      end
      repeat (d) @(negedge clk);
      prev = m_cur;
      run_spawn(1, 0, 1'b0, 0, seen);
      dx = int'(cur_x) - prev;
      if (dx < 0) dx = -dx;
      checks++;
      if (seen != TRIES || dx != MIN_GAP) begin
         failures++;
         $display("FAIL exhaust_gap got=%0d cycles dx=%0d want=%0d cycles dx=%0d",
                  seen, dx, TRIES, MIN_GAP);
      end
   endtask

   task automatic test_req_during_fall();
      int d;
      logic [1:0] bd;
      run_spawn(2, 1, 1'b1, 0, d);
      repeat (3) begin
         @(negedge clk);
         checks++;
         bd = {spawn_busy, spawn_done};
         if (bd !== 2'b00) begin
            failures++;
            $display("FAIL req_dropped got=%b want=00", bd);
         end
      end
   endtask

   task automatic test_back_to_back(input int n);
      int d;
      for (int i = 0; i < n; i++) begin
         run_spawn($urandom_range(0, 2), $urandom_range(0, DIV - 1), 1'(i % 7 == 3), 0, d);
         checks++;
         if (!(stage_w2 == 10'd40 || stage_w2 == 10'd60 || stage_w2 == 10'd80 ||
               stage_w2 == 10'd100)) begin
            failures++;
            $display("FAIL width_set got=%0d want=40/60/80/100", stage_w2);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_fall();
      int d;
      run_spawn(60, 0, 1'b0, 50, d);
      test_reset(1);
      run_spawn(1, 2, 1'b0, 0, d);
   endtask

   initial begin
      test_reset(3);
      test_idle_fall_fin();
      test_spawn_basic();
      test_exhaust();
      test_req_during_fall();
      test_back_to_back(1000);
      test_reset_mid_fall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
